cla_seq_adder: RTL
==================

# cla_seq_adder

Multi-cycle WIDTH-bit adder/subtractor. One shared 4-bit carry-lookahead slice (`carrylookahead`) is reused across cycles, processing one nibble per cycle, least-significant first. The inter-nibble carry is held in a register and derived from the slice's group P/G outputs. Sits in the ALU as the area-optimised add/sub path, with valid/ready handshakes on both the operand side and the result side.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 4 and ≥ 8
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- start_valid  in  1  operands and op present
- start_ready  out  1  block can accept an op (high only in IDLE)
- a  in  WIDTH  operand A, sampled at accept
- b  in  WIDTH  operand B, sampled at accept
- sub  in  1  0 = A+B, 1 = A−B, sampled at accept
- res_valid  out  1  result registers valid
- res_ready  in  1  consumer takes result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB nibble (for sub: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  sum == 0

## Operation
- Reset: clk and rst are the only timing inputs; reset is synchronous and active-high. After reset, state = IDLE; start_ready=1; res_valid=0; sum=0; cout=0; ovf=0; zero=0; nibble counter=0; carry register=0.
- States:
  - IDLE → RUN on start_valid && start_ready. At that edge, latch a into opA and (sub ? ~b : b) into opB. Set carry register = sub and counter = 0. Clear sum, cout, ovf, zero.
  - RUN, each cycle:
    - slice input x = opA[4k+3:4k], y = opB[4k+3:4k], c0 = carry register, where k = counter.
    - Write slice sum into sum[4k+3:4k].
    - Update carry register with G | (P & carry register).
    - Increment counter.
  - RUN → DONE on the edge that processes k = WIDTH/4−1. On that same edge:
    - cout = G | (P & c_in).
    - ovf = (opA[MSB] == opB[MSB]) && (new sum[MSB] != opA[MSB]).
    - zero = (final full sum == 0).
  - DONE: res_valid=1. All result outputs are held stable. DONE → IDLE on res_ready. The result is dropped and res_valid falls at that edge.
- start_valid is ignored outside IDLE: no queuing, and a, b, sub are not sampled.
- Arithmetic: the subtraction form is A + ~B + 1. Counter width is clog2(WIDTH/4). The slice sum bits are used directly; the slice's ripple carries are not used between nibbles.
- sum is partially updated during RUN. Consumers may sample it only while res_valid=1.

## Timing
- Accept edge = T0. Nibble k is written at edge T0+k+1.
- res_valid rises after edge T0+WIDTH/4, i.e. 8 cycles for WIDTH=32.
- If res_ready is already high when res_valid rises, the result is consumed at the next edge. start_ready rises after that edge, and the next op can be accepted one cycle later.
- Minimum op-to-op spacing is WIDTH/4+2 cycles.
- Combinational paths: start_ready depends on state only. res_valid depends on state only. There is no combinational path from any input to any output.
- rst has priority over every other event in any state, including RUN mid-computation and DONE with res_ready high. The next state is IDLE with the reset values listed above, and any in-flight op is discarded.
- A start_valid in the same cycle that rst is high is not accepted.

## Test plan
- Full-length carry ripple, WIDTH=32: 0x0000_0001 + 0xFFFF_FFFF, sub=0 → sum=0, cout=1, ovf=0, zero=1. res_valid rises exactly 8 cycles after the accept edge.
- Signed overflow: 0x7FFF_FFFF + 0x0000_0001 → sum=0x8000_0000, cout=0, ovf=1, zero=0. Also 0x0FFF_FFFF + 1 → 0x1000_0000, cout=0, ovf=0.
- Subtraction:
  - 5 − 7 → sum=0xFFFF_FFFE, cout=0, ovf=0.
  - 0x8000_0000 − 1 → sum=0x7FFF_FFFF, cout=1, ovf=1.
  - 9 − 9 → sum=0, cout=1, zero=1.
- Backpressure: hold res_ready=0 for 5 cycles in DONE while driving start_valid=1 with new operands → sum, cout, ovf, zero stay constant; start_ready=0; the new op is not accepted. Raise res_ready → IDLE next cycle, then the op is accepted.
- Reset mid-op: assert rst for one cycle during RUN at k=3 → next cycle state IDLE, start_ready=1, res_valid=0, all result outputs 0. A following 2 + 3 op yields sum=5 with correct latency.
- Back-to-back: two ops with res_ready tied high → second accept occurs 1 cycle after first result handoff. Both results are correct, and the second op's fields are not corrupted by the first op's residual state (carry, counter).

Source files
------------

// File: rtl/cla_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : cla_seq_adder (with helper slice carrylookahead)
//  Purpose  : Multi-cycle WIDTH-bit adder/subtractor that reuses a single
//             4-bit carry-lookahead slice, one nibble per clock, LSB first.
//             Valid/ready handshakes on operand and result sides.
//  Revision : 1.0  initial release
// ============================================================================

// 4-bit carry-lookahead slice: nibble sum plus group propagate/generate.
module carrylookahead (
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  input  logic       i_c0,
  output logic [3:0] o_s,
  output logic       o_p,
  output logic       o_g
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = i_x ^ i_y;
  assign w_g = i_x & i_y;

  // Internal carries are resolved in parallel from the per-bit P/G terms.
  assign w_c[0] = i_c0;
  assign w_c[1] = w_g[0] | (w_p[0] & i_c0);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c0);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_c0);

  assign o_s = w_p ^ w_c;
  assign o_p = &w_p;
  assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

module cla_seq_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int C_NIB = WIDTH / 4;
  localparam int C_CW  = $clog2(C_NIB);
  localparam logic [C_CW-1:0] C_LAST = C_CW'(C_NIB - 1);

  generate
    if ((WIDTH % 4 != 0) || (WIDTH < 8)) begin : g_width_check
      $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_carry;
  logic [C_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [C_CW+1:0]  w_base;
  logic [3:0]       w_s;
  logic             w_p;
  logic             w_g;
  logic             w_cnext;
  logic             w_last;

  // Bit offset of the nibble being processed this cycle.
  assign w_base  = {r_cnt, 2'b00};
  assign w_last  = (r_cnt == C_LAST);
  assign w_cnext = w_g | (w_p & r_carry);

  carrylookahead u_slice (
    .i_x  (r_opa[w_base +: 4]),
    .i_y  (r_opb[w_base +: 4]),
    .i_c0 (r_carry),
    .o_s  (w_s),
    .o_p  (w_p),
    .o_g  (w_g)
  );

  // State register; reset wins over every handshake.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: accept in IDLE, walk nibbles in RUN, hand off in DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_valid) w_next = S_RUN;
      S_RUN:   if (w_last)      w_next = S_DONE;
      S_DONE:  if (res_ready)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands at accept, then fold one nibble per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
          end
        end
        S_RUN: begin
          r_sum[w_base +: 4] <= w_s;
          r_carry            <= w_cnext;
          r_cnt              <= r_cnt + C_CW'(1);
          if (w_last) begin
            // The top nibble is being written now, so combine it with the
            // already-stored lower nibbles for the flags.
            r_cout <= w_cnext;
            r_ovf  <= (r_opa[WIDTH-1] == r_opb[WIDTH-1]) && (w_s[3] != r_opa[WIDTH-1]);
            r_zero <= ({w_s, r_sum[WIDTH-5:0]} == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign res_valid   = (r_state == S_DONE);
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign ovf         = r_ovf;
  assign zero        = r_zero;

endmodule
`default_nettype wire
